ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 scancode-set-2 decoder between PS2_Controller byte output and game logic.

---
 rtl/ps2_key_tracker.sv | 188 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 scancode-set-2 decoder that tracks the held state of
// a configurable set of keys and emits one-cycle press pulses.
// Optional build macro: PS2_TYPEMATIC_PULSE_EN (typematic repeats also pulse).
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h172, 9'h16B, 9'h175},
  parameter int                    TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [7:0]          last_code,
  output logic                last_ext,
  output logic                last_break,
  output logic                code_valid
);

  // A zero timeout disables the counter, which then shrinks to a single unused bit.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [2:0]            skip_q, skip_d;
  logic [NUM_KEYS-1:0]   held_q, held_d;
  logic [NUM_KEYS-1:0]   pulse_q, pulse_d;
  logic [7:0]            code_q, code_d;
  logic                  ext_q, ext_d;
  logic                  brk_q, brk_d;
  logic                  cv_q, cv_d;

  logic                  done;
  logic                  c_ext;
  logic                  c_brk;
  logic                  special;

  // Controller bookkeeping bytes that must not be mistaken for key codes.
  always_comb begin
    special = 1'b0;
    case (received_data)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: special = 1'b1;
      default: special = 1'b0;
    endcase
  end

  // Next-state: prefix parsing, timeout, and key table update on completion.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    skip_d  = skip_q;
    held_d  = held_q;
    pulse_d = '0;
    code_d  = code_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    cv_d    = 1'b0;
    done    = 1'b0;
    c_ext   = 1'b0;
    c_brk   = 1'b0;

    if (received_data_en) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (received_data == 8'hE0) begin
            state_d = EXT;
          end else if (received_data == 8'hF0) begin
            state_d = BRK;
          end else if (received_data == 8'hE1) begin
            state_d = SKIP;
            skip_d  = 3'd7;
          end else if (special) begin
            if (received_data == 8'hAA) held_d = '0;
          end else begin
            done = 1'b1;
          end
        end
        EXT: begin
          if (received_data == 8'hF0) state_d = EXT_BRK;
          else if (received_data != 8'hE0) begin
            done  = 1'b1;
            c_ext = 1'b1;
          end
        end
        BRK: begin
          if (received_data == 8'hE0) state_d = EXT_BRK;
          else if (received_data != 8'hF0) begin
            done  = 1'b1;
            c_brk = 1'b1;
          end
        end
        EXT_BRK: begin
          if (received_data != 8'hE0 && received_data != 8'hF0) begin
            done  = 1'b1;
            c_ext = 1'b1;
            c_brk = 1'b1;
          end
        end
        SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (TO_EN && state_q != IDLE) begin
      if (tmo_q == TO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (done) begin
      state_d = IDLE;
      code_d  = received_data;
      ext_d   = c_ext;
      brk_d   = c_brk;
      cv_d    = 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (KEY_CODES[9*i +: 9] == {c_ext, received_data}) begin
          if (c_brk) begin
            held_d[i] = 1'b0;
          end else begin
`ifdef PS2_TYPEMATIC_PULSE_EN
            pulse_d[i] = 1'b1;
`else
            pulse_d[i] = ~held_q[i];
`endif
            held_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State and registered outputs; reset overrides any strobe in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      skip_q  <= '0;
      held_q  <= '0;
      pulse_q <= '0;
      code_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      skip_q  <= skip_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cv_q    <= cv_d;
    end
  end

  assign key_held        = held_q;
  assign key_press_pulse = pulse_q;
  assign last_code       = code_q;
  assign last_ext        = ext_q;
  assign last_break      = brk_q;
  assign code_valid      = cv_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios followed by random byte
// streams, all checked against a prefix-flag reference model.
module tb_ps2_key_tracker;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rd  = 8'h00;
  logic       en  = 1'b0;
  logic [3:0] key_held, key_press_pulse;
  logic [7:0] last_code;
  logic       last_ext, last_break, code_valid;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [8:0] kc [4] = '{9'h175, 9'h16B, 9'h172, 9'h174};
  logic [3:0] m_held, m_pulse;
  logic [7:0] m_code;
  logic       m_ext, m_brk, m_cv;
  logic       f_ext, f_brk;
  int         skip_rem, gap;
  int         cv_seen, p0_seen;

  ps2_key_tracker #(.NUM_KEYS(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .reset(rst), .received_data(rd), .received_data_en(en),
    .key_held(key_held), .key_press_pulse(key_press_pulse), .last_code(last_code),
    .last_ext(last_ext), .last_break(last_break), .code_valid(code_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF);
  endfunction

  task automatic model_clear();
    m_held = '0; m_pulse = '0; m_code = '0; m_ext = 0; m_brk = 0; m_cv = 0;
    f_ext = 0; f_brk = 0; skip_rem = 0; gap = 0;
  endtask

  task automatic model_cycle(input logic e, input logic [7:0] d);
    bit pending;
    m_pulse = '0;
    m_cv    = 0;
    pending = f_ext || f_brk || (skip_rem > 0);
    if (!e) begin
      if (pending) begin
        gap++;
        if (gap >= TO) begin
          f_ext = 0; f_brk = 0; skip_rem = 0; gap = 0;
        end
      end else gap = 0;
      return;
    end
    gap = 0;
    if (skip_rem > 0) skip_rem--;
    else if (!f_ext && !f_brk && d == 8'hE1) skip_rem = 7;
    else if (d == 8'hE0) f_ext = 1;
    else if (d == 8'hF0) f_brk = 1;
    else if (!f_ext && !f_brk && is_special(d)) begin
      if (d == 8'hAA) m_held = '0;
    end else begin
      m_code = d; m_ext = f_ext; m_brk = f_brk; m_cv = 1;
      for (int i = 0; i < 4; i++) begin
        if (kc[i] == {f_ext, d}) begin
          if (f_brk) m_held[i] = 1'b0;
          else begin
`ifdef PS2_TYPEMATIC_PULSE_EN
            m_pulse[i] = 1'b1;
`else
            if (!m_held[i]) m_pulse[i] = 1'b1;
`endif
            m_held[i] = 1'b1;
          end
        end
      end
      f_ext = 0; f_brk = 0;
    end
  endtask

  task automatic compare_all();
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("key_press_pulse", 32'(key_press_pulse), 32'(m_pulse));
    chk("code_valid", 32'(code_valid), 32'(m_cv));
    chk("last_code", 32'(last_code), 32'(m_code));
    chk("last_ext", 32'(last_ext), 32'(m_ext));
    chk("last_break", 32'(last_break), 32'(m_brk));
    if (code_valid === 1'b1) cv_seen++;
    if (key_press_pulse[0] === 1'b1) p0_seen++;
  endtask

  task automatic cyc(input logic e, input logic [7:0] d);
    @(negedge clk);
    en = e; rd = d;
    model_cycle(e, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 1; rd = 8'h74;
    model_clear();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 0; en = 0;
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h74, 8'h72, 8'h6B, 8'h75,
                            8'hAA, 8'hFA, 8'h14, 8'hE0, 8'hF0};

  initial begin
    model_clear();
    cv_seen = 0; p0_seen = 0;
    do_reset();
    do_reset();

    // extended make of "right"
    send(8'hE0); send(8'h74);
    chk("ext_make_held", 32'(key_held), 32'h8);
    chk("ext_make_pulse", 32'(key_press_pulse), 32'h8);
    chk("ext_make_code", 32'({last_ext, last_break, last_code}), 32'h274);
    idle(1);
    chk("pulse_one_cycle", 32'(key_press_pulse), 32'h0);

    // extended break
    cv_seen = 0;
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("ext_break_held", 32'(key_held), 32'h0);
    chk("ext_break_flags", 32'({last_ext, last_break}), 32'h3);
    idle(2);
    chk("ext_break_cv_count", 32'(cv_seen), 32'd1);

    // non-extended 75 does not touch "up"
    send(8'h75);
    chk("nonext_held", 32'(key_held), 32'h0);
    chk("nonext_cv", 32'({code_valid, last_ext}), 32'h2);

    // typematic repeat
    p0_seen = 0;
    repeat (3) begin send(8'hE0); send(8'h75); end
    idle(1);
    chk("typematic_held0", 32'(key_held[0]), 32'h1);
`ifdef PS2_TYPEMATIC_PULSE_EN
    chk("typematic_pulses", 32'(p0_seen), 32'd3);
`else
    chk("typematic_pulses", 32'(p0_seen), 32'd1);
`endif

    // timeout boundary: 15 quiet cycles keeps the prefix, 16 drops it
    send(8'hE0); idle(TO - 1); send(8'h74);
    chk("no_timeout_ext", 32'({last_ext, key_held[3]}), 32'h3);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); idle(TO); send(8'h74);
    chk("timeout_nonext", 32'({last_ext, key_held[3]}), 32'h0);

    // pause sequence produces nothing and returns to IDLE
    cv_seen = 0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_no_cv", 32'(cv_seen), 32'd0);
    send(8'h6B);
    chk("pause_then_idle", 32'({code_valid, last_ext, last_code}), 32'h26B);

    // BAT ok clears held keys
    send(8'hE0); send(8'h6B);
    chk("left_held", 32'(key_held), 32'h3);
    cv_seen = 0;
    send(8'hAA);
    chk("aa_clears", 32'(key_held), 32'h0);
    chk("aa_no_cv", 32'(cv_seen), 32'd0);

    // reset in the middle of E0 F0
    send(8'hE0); send(8'h72); send(8'hE0); send(8'hF0);
    do_reset();
    chk("reset_mid_outputs", 32'({key_held, key_press_pulse, last_code, last_ext, last_break, code_valid}), 32'h0);
    send(8'h74);
    chk("after_reset_nonext", 32'({last_ext, last_break, key_held}), 32'h0);

    // random stream
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 40) == 0) idle($urandom_range(TO - 2, TO + 2));
      else if ($urandom_range(0, 400) == 0) do_reset();
      else if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'($urandom));
      else if ($urandom_range(0, 9) == 0) send(8'($urandom));
      else send(pool[$urandom_range(0, 11)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
